alu: RTL and testbench

//  RiSC-16 datapath ALU: ADD, NAND, PASS1 (for LUI/JALR paths) and EQ compare (for BEQ).
//  - Result path is purely combinational and feeds the writeback/branch logic directly.
//  - A registered copy of the result plus status flags is also provided, for pipeline and debug use.
//  - Sits between the register-file read ports / immediate mux and the writeback mux.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_status_reg.sv | 37 +++
 rtl/alu.sv | 64 ++++++
 tb/tb_alu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the RiSC-16 ALU: width, op encoding and select priority.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADD,
        OP_NAND,
        OP_PASS1,
        OP_EQ
    } alu_op_e;

    // Selects are nominally one-hot; overlaps resolve ADD > NAND > PASS1 > EQ.
    function automatic alu_op_e alu_decode(input logic sel_add, input logic sel_nand,
                                           input logic sel_pass1, input logic sel_eq);
        if (sel_add)        return OP_ADD;
        else if (sel_nand)  return OP_NAND;
        else if (sel_pass1) return OP_PASS1;
        else if (sel_eq)    return OP_EQ;
        else                return OP_NONE;
    endfunction

    function automatic logic multi_sel(input logic sel_add, input logic sel_nand,
                                       input logic sel_pass1, input logic sel_eq);
        logic [2:0] cnt;
        cnt = {2'b00, sel_add} + {2'b00, sel_nand} + {2'b00, sel_pass1} + {2'b00, sel_eq};
        return cnt > 3'd1;
    endfunction

endpackage

// File: rtl/alu_status_reg.sv
// Registered copy of the ALU result and status flags; async reset clears everything.
module alu_status_reg
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] result,
    input  logic             eq,
    input  logic             carry,
    input  logic             zero,
    input  logic             sel_err,
    output logic [WIDTH-1:0] result_q,
    output logic             eq_q,
    output logic             carry_q,
    output logic             zero_q,
    output logic             sel_err_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= '0;
            eq_q      <= 1'b0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            result_q  <= result;
            eq_q      <= eq;
            carry_q   <= carry;
            zero_q    <= zero;
            sel_err_q <= sel_err;
        end
    end

endmodule

// File: rtl/alu.sv
// RiSC-16 datapath ALU: combinational ADD/NAND/PASS1/EQ result plus a registered status copy.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_src1,
    input  logic [WIDTH-1:0] alu_src2,
    input  logic             ADD,
    input  logic             NAND,
    input  logic             PASS1,
    input  logic             EQ,
    output logic [WIDTH-1:0] alu_out,
    output logic             eq_out,
    output logic [WIDTH-1:0] alu_out_q,
    output logic             eq_out_q,
    output logic             carry_q,
    output logic             zero_q,
    output logic             sel_err_q
);

    alu_op_e        op;
    logic [WIDTH:0] sum;
    logic           carry;
    logic           sel_err;

    assign op      = alu_decode(ADD, NAND, PASS1, EQ);
    assign sel_err = multi_sel(ADD, NAND, PASS1, EQ);
    assign sum     = {1'b0, alu_src1} + {1'b0, alu_src2};
    // Branch decode gates eq_out, so it is valid whatever op is selected.
    assign eq_out  = (alu_src1 == alu_src2);

    always_comb begin
        alu_out = '0;
        carry   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_out = sum[WIDTH-1:0];
                carry   = sum[WIDTH];
            end
            OP_NAND:  alu_out = ~(alu_src1 & alu_src2);
            OP_PASS1: alu_out = alu_src1;
            default:  alu_out = '0;
        endcase
    end

    alu_status_reg #(.WIDTH(WIDTH)) u_status (
        .clk       (clk),
        .rst       (rst),
        .result    (alu_out),
        .eq        (eq_out),
        .carry     (carry),
        .zero      (alu_out == '0),
        .sel_err   (sel_err),
        .result_q  (alu_out_q),
        .eq_q      (eq_out_q),
        .carry_q   (carry_q),
        .zero_q    (zero_q),
        .sel_err_q (sel_err_q)
    );

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the RiSC-16 ALU (combinational and registered paths).
module tb_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] alu_src1, alu_src2;
    logic        ADD, NAND, PASS1, EQ;
    logic [15:0] alu_out, alu_out_q;
    logic        eq_out, eq_out_q, carry_q, zero_q, sel_err_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .ADD(ADD), .NAND(NAND), .PASS1(PASS1), .EQ(EQ),
        .alu_out(alu_out), .eq_out(eq_out), .alu_out_q(alu_out_q), .eq_out_q(eq_out_q),
        .carry_q(carry_q), .zero_q(zero_q), .sel_err_q(sel_err_q)
    );

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel);
        alu_src1 = a;
        alu_src2 = b;
        {ADD, NAND, PASS1, EQ} = sel;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(16'h0000, 16'h0000, 4'b0000);
        tick();
        checks++;
        if ({alu_out_q, eq_out_q, carry_q, zero_q, sel_err_q} !== 20'h0) begin
            errors++;
            $display("FAIL reset_q: got %h/%b%b%b%b want 0", alu_out_q, eq_out_q, carry_q, zero_q, sel_err_q);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        drive(16'h0005, 16'h0003, 4'b1000);
        checks++;
        if (alu_out !== 16'h0008) begin errors++; $display("FAIL add_comb: got %h want 0008", alu_out); end
        tick();
        checks++;
        if ({alu_out_q, carry_q, zero_q, sel_err_q} !== {16'h0008, 3'b000}) begin
            errors++;
            $display("FAIL add_q: got %h c%b z%b e%b want 0008 c0 z0 e0", alu_out_q, carry_q, zero_q, sel_err_q);
        end
    endtask

    task automatic test_nand();
        drive(16'hFFFF, 16'h00FF, 4'b0100);
        checks++;
        if (alu_out !== 16'hFF00) begin errors++; $display("FAIL nand_comb: got %h want ff00", alu_out); end
        tick();
        checks++;
        if (alu_out_q !== 16'hFF00) begin errors++; $display("FAIL nand_q: got %h want ff00", alu_out_q); end
        drive(16'hFFFF, 16'hFFFF, 4'b0100);
        checks++;
        if (alu_out !== 16'h0000) begin errors++; $display("FAIL nand_ones: got %h want 0000", alu_out); end
        // An operand pair that would carry under ADD must not carry under NAND.
        drive(16'hFFFF, 16'h0001, 4'b0100);
        tick();
        checks++;
        if ({alu_out_q, carry_q} !== {16'hFFFE, 1'b0}) begin
            errors++;
            $display("FAIL nand_carry: got %h c%b want fffe c0", alu_out_q, carry_q);
        end
    endtask

    task automatic test_pass1();
        drive(16'hDEAD, 16'hBEEF, 4'b0010);
        checks++;
        if (alu_out !== 16'hDEAD) begin errors++; $display("FAIL pass1_comb: got %h want dead", alu_out); end
    endtask

    task automatic test_eq();
        drive(16'hAAAA, 16'hAAAA, 4'b0001);
        checks++;
        if ({eq_out, alu_out} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL eq_comb_true: got eq%b %h want eq1 0000", eq_out, alu_out);
        end
        tick();
        checks++;
        if ({eq_out_q, zero_q} !== 2'b11) begin
            errors++;
            $display("FAIL eq_q_true: got eq%b z%b want eq1 z1", eq_out_q, zero_q);
        end
        drive(16'hAAAA, 16'h1234, 4'b0001);
        checks++;
        if (eq_out !== 1'b0) begin errors++; $display("FAIL eq_comb_false: got %b want 0", eq_out); end
        tick();
        checks++;
        if ({eq_out_q, zero_q} !== 2'b01) begin
            errors++;
            $display("FAIL eq_q_false: got eq%b z%b want eq0 z1", eq_out_q, zero_q);
        end
        // eq_out ignores the selects.
        drive(16'h0042, 16'h0042, 4'b1000);
        checks++;
        if ({eq_out, alu_out} !== {1'b1, 16'h0084}) begin
            errors++;
            $display("FAIL eq_under_add: got eq%b %h want eq1 0084", eq_out, alu_out);
        end
    endtask

    task automatic test_boundary();
        drive(16'hFFFF, 16'h0001, 4'b1000);
        checks++;
        if (alu_out !== 16'h0000) begin errors++; $display("FAIL wrap_comb: got %h want 0000", alu_out); end
        tick();
        checks++;
        if ({alu_out_q, carry_q, zero_q} !== {16'h0000, 2'b11}) begin
            errors++;
            $display("FAIL wrap_q: got %h c%b z%b want 0000 c1 z1", alu_out_q, carry_q, zero_q);
        end
        drive(16'h8000, 16'h8000, 4'b1000);
        tick();
        checks++;
        if ({alu_out_q, carry_q} !== {16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL msb_q: got %h c%b want 0000 c1", alu_out_q, carry_q);
        end
        drive(16'h1234, 16'h4321, 4'b0000);
        checks++;
        if (alu_out !== 16'h0000) begin errors++; $display("FAIL none_comb: got %h want 0000", alu_out); end
    endtask

    task automatic test_priority();
        drive(16'h0005, 16'h0003, 4'b1100);
        checks++;
        if (alu_out !== 16'h0008) begin errors++; $display("FAIL prio_add_nand: got %h want 0008", alu_out); end
        tick();
        checks++;
        if ({alu_out_q, sel_err_q} !== {16'h0008, 1'b1}) begin
            errors++;
            $display("FAIL sel_err_set: got %h e%b want 0008 e1", alu_out_q, sel_err_q);
        end
        drive(16'hF0F0, 16'hFF00, 4'b0110);
        checks++;
        if (alu_out !== 16'h0FFF) begin errors++; $display("FAIL prio_nand_pass: got %h want 0fff", alu_out); end
        drive(16'hF0F0, 16'hF0F0, 4'b0011);
        checks++;
        if (alu_out !== 16'hF0F0) begin errors++; $display("FAIL prio_pass_eq: got %h want f0f0", alu_out); end
        drive(16'h0001, 16'h0002, 4'b1000);
        tick();
        checks++;
        if ({alu_out_q, sel_err_q} !== {16'h0003, 1'b0}) begin
            errors++;
            $display("FAIL sel_err_clear: got %h e%b want 0003 e0", alu_out_q, sel_err_q);
        end
    endtask

    task automatic test_async_reset();
        drive(16'h1234, 16'h1111, 4'b1100);
        tick();
        checks++;
        if ({alu_out_q, sel_err_q} !== {16'h2345, 1'b1}) begin
            errors++;
            $display("FAIL pre_rst_q: got %h e%b want 2345 e1", alu_out_q, sel_err_q);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({alu_out_q, eq_out_q, carry_q, zero_q, sel_err_q} !== 20'h0) begin
            errors++;
            $display("FAIL rst_async: got %h/%b%b%b%b want 0", alu_out_q, eq_out_q, carry_q, zero_q, sel_err_q);
        end
        checks++;
        if (alu_out !== 16'h2345) begin errors++; $display("FAIL rst_comb: got %h want 2345", alu_out); end
        tick();
        tick();
        checks++;
        if ({alu_out_q, sel_err_q} !== 17'h0) begin
            errors++;
            $display("FAIL rst_hold: got %h e%b want 0 e0", alu_out_q, sel_err_q);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (alu_out_q !== 16'h0000) begin errors++; $display("FAIL rst_release: got %h want 0000", alu_out_q); end
        tick();
        checks++;
        if ({alu_out_q, sel_err_q} !== {16'h2345, 1'b1}) begin
            errors++;
            $display("FAIL rst_resume: got %h e%b want 2345 e1", alu_out_q, sel_err_q);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_nand();
        test_pass1();
        test_eq();
        test_boundary();
        test_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
